// File: rtl/hash_arbiter_pkg.sv
// Shared types for the hash arbiter: word width, FSM state encoding and
// digest type. Imported by the interface, picker and top.
package hash_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } hash_arb_state_t;

   typedef logic [WORD_W-1:0] digest_t;

endpackage

// File: rtl/hash_arbiter_if.sv
// Bus bundle between the requesters / hash core and the arbiter.
// slave  : arbiter side (consumes requests and core results)
// master : client/core side (drives requests and core results)
interface hash_arbiter_if
   import hash_pkg::*;
#(
   parameter int NUM_REQ = 4
);

   localparam int ID_W = $clog2(NUM_REQ);

   // Requester side
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*WORD_W-1:0] req_msg;
   logic [NUM_REQ*WORD_W-1:0] req_iv;
   logic [NUM_REQ-1:0]        req_ready;

   // Hash core side
   logic                      core_start;
   logic [WORD_W-1:0]         core_m;
   logic [WORD_W-1:0]         core_iv;
   logic                      core_done;
   digest_t                   core_d;

   // Shared response port
   logic                      rsp_valid;
   logic [ID_W-1:0]           rsp_id;
   digest_t                   rsp_digest;
   logic                      rsp_err;
   logic                      busy;

   modport slave (
      input  req_valid, req_msg, req_iv, core_done, core_d,
      output req_ready, core_start, core_m, core_iv,
             rsp_valid, rsp_id, rsp_digest, rsp_err, busy
   );

   modport master (
      output req_valid, req_msg, req_iv, core_done, core_d,
      input  req_ready, core_start, core_m, core_iv,
             rsp_valid, rsp_id, rsp_digest, rsp_err, busy
   );

endinterface

// File: rtl/hash_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requester found scanning
// upward from last_grant+1 (wrapping modulo N) wins.
module rr_picker
   import hash_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] last_grant_i,
   output logic [N-1:0]         grant_onehot_o,
   output logic [$clog2(N)-1:0] grant_id_o,
   output logic                 any_o
);

   localparam int ID_W = $clog2(N);

   // Scan farthest-first so the nearest requester after last_grant overwrites last
   always_comb begin
      int idx;
      idx            = 0;
      grant_onehot_o = '0;
      grant_id_o     = '0;
      any_o          = |req_i;
      for (int k = N; k >= 1; k--) begin
         idx = (int'(last_grant_i) + k) % N;
         if (req_i[idx]) begin
            grant_id_o = ID_W'(idx);
         end
      end
      if (any_o) begin
         grant_onehot_o[grant_id_o] = 1'b1;
      end
   end

endmodule

// File: rtl/hash_arbiter.sv
// hash_arbiter: shares one hash core among NUM_REQ requesters.
// IDLE accepts one request (round-robin), LAUNCH pulses core_start,
// WAIT collects the digest, RESP pulses the shared response port.
// Optional build macro HASH_ARB_TIMEOUT_EN adds a WAIT watchdog that
// returns an error response after TIMEOUT_CYCLES cycles without core_done.
module hash_arbiter
   import hash_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic           clk,
   input logic           rst,
   hash_arbiter_if.slave bus
);

   localparam int ID_W = $clog2(NUM_REQ);

   hash_arb_state_t   state_q, state_d;
   logic [ID_W-1:0]   cur_id_q, cur_id_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [WORD_W-1:0] msg_q, msg_d;
   logic [WORD_W-1:0] iv_q, iv_d;
   digest_t           digest_q, digest_d;

   logic [NUM_REQ-1:0] grant_onehot;
   logic [ID_W-1:0]    grant_id;
   logic               grant_any;

   logic [WORD_W-1:0] msg_slice [NUM_REQ];
   logic [WORD_W-1:0] iv_slice  [NUM_REQ];

   // Unpack the flat request buses into per-requester words
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign msg_slice[gi] = bus.req_msg[gi*WORD_W +: WORD_W];
         assign iv_slice[gi]  = bus.req_iv[gi*WORD_W +: WORD_W];
      end
   endgenerate

   rr_picker #(
      .N (NUM_REQ)
   ) u_picker (
      .req_i          (bus.req_valid),
      .last_grant_i   (last_grant_q),
      .grant_onehot_o (grant_onehot),
      .grant_id_o     (grant_id),
      .any_o          (grant_any)
   );

`ifdef HASH_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             timeout_hit;
   logic             err_q, err_d;

   // Expiry is the WAIT cycle whose increment would reach TIMEOUT_CYCLES
   assign cnt_inc     = cnt_q + CNT_W'(1);
   assign timeout_hit = (state_q == WAIT) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

   // Watchdog counter: cleared on launch, counts every WAIT cycle
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == LAUNCH) begin
         cnt_d = '0;
      end else if (state_q == WAIT) begin
         cnt_d = cnt_inc;
      end
   end

   // Error flag is decided when leaving WAIT; core_done beats expiry
   always_comb begin
      err_d = err_q;
      if (state_q == WAIT) begin
         if (bus.core_done) begin
            err_d = 1'b0;
         end else if (timeout_hit) begin
            err_d = 1'b1;
         end
      end
   end

   // Watchdog registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus.rsp_err = err_q;
`else
   // TIMEOUT_CYCLES has no effect without the watchdog; keep it referenced
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
   end

   assign bus.rsp_err = 1'b0;
`endif

   // Next-state and datapath-load decisions for the four-state job FSM
   always_comb begin
      state_d      = state_q;
      cur_id_d     = cur_id_q;
      last_grant_d = last_grant_q;
      rsp_id_d     = rsp_id_q;
      msg_d        = msg_q;
      iv_d         = iv_q;
      digest_d     = digest_q;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               cur_id_d = grant_id;
               msg_d    = msg_slice[grant_id];
               iv_d     = iv_slice[grant_id];
               state_d  = LAUNCH;
            end
         end
         LAUNCH: begin
            // core_done deliberately not looked at here: a done left over
            // from the previous job must not complete this one
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.core_done) begin
               digest_d = bus.core_d;
               rsp_id_d = cur_id_q;
               state_d  = RESP;
            end
`ifdef HASH_ARB_TIMEOUT_EN
            else if (timeout_hit) begin
               digest_d = '0;
               rsp_id_d = cur_id_q;
               state_d  = RESP;
            end
`endif
         end
         RESP: begin
            last_grant_d = cur_id_q;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any job in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cur_id_q     <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         rsp_id_q     <= '0;
         msg_q        <= '0;
         iv_q         <= '0;
         digest_q     <= '0;
      end else begin
         state_q      <= state_d;
         cur_id_q     <= cur_id_d;
         last_grant_q <= last_grant_d;
         rsp_id_q     <= rsp_id_d;
         msg_q        <= msg_d;
         iv_q         <= iv_d;
         digest_q     <= digest_d;
      end
   end

   // Outputs: ready only in IDLE and never while reset is held
   assign bus.req_ready  = (state_q == IDLE && !rst) ? grant_onehot : '0;
   assign bus.core_start = (state_q == LAUNCH);
   assign bus.core_m     = msg_q;
   assign bus.core_iv    = iv_q;
   assign bus.rsp_valid  = (state_q == RESP);
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_digest = digest_q;
   assign bus.busy       = (state_q != IDLE);

endmodule
